// File: rtl/pkhdr_codec_if.sv
// pkhdr_codec_if: control, header and bit-stream signals between the packet controller and the header codec
interface pkhdr_codec_if #(
  parameter int HDR_BITS = 10,
  parameter int HEC_BITS = 8,
  parameter int WHT_BITS = 7
);
  logic                p_1us;
  logic                start_p;
  logic                stop_p;
  logic                pk_encode;
  logic                whiten_en;
  logic [HEC_BITS-1:0] hec_init;
  logic [WHT_BITS-1:0] wht_init;
  logic [HDR_BITS-1:0] hdr_tx;
  logic                rx_bit;
  logic                tx_bit;
  logic                tx_valid;
  logic [HDR_BITS-1:0] hdr_rx;
  logic                busy;
  logic                done_p;
  logic                hec_ok;
  modport master (
    output p_1us, start_p, stop_p, pk_encode, whiten_en, hec_init, wht_init, hdr_tx, rx_bit,
    input  tx_bit, tx_valid, hdr_rx, busy, done_p, hec_ok
  );
  modport slave (
    input  p_1us, start_p, stop_p, pk_encode, whiten_en, hec_init, wht_init, hdr_tx, rx_bit,
    output tx_bit, tx_valid, hdr_rx, busy, done_p, hec_ok
  );
endinterface

// File: rtl/pkhdr_codec.sv
// pkhdr_codec: packet-header serialiser/deserialiser with HEC, whitening and rate-1/N repetition FEC
module pkhdr_codec #(
  parameter int                  HDR_BITS = 10,
  parameter int                  HEC_BITS = 8,
  parameter logic [HEC_BITS-1:0] HEC_POLY = 8'hA7,
  parameter int                  WHT_BITS = 7,
  parameter logic [WHT_BITS-1:0] WHT_POLY = 7'h11,
  parameter int                  FEC_REP  = 3
) (
  input logic          clk_6M,
  input logic          rstz,
  pkhdr_codec_if.slave io
);
  localparam int RW  = FEC_REP > 1 ? $clog2(FEC_REP) : 1;
  localparam int SD  = FEC_REP > 1 ? FEC_REP - 1 : 1;
  localparam int TOT = HDR_BITS + HEC_BITS;
  localparam int BW  = $clog2(TOT);
  localparam int CW  = $clog2(FEC_REP + 1);
  typedef enum logic [1:0] {IDLE, HDR, HEC, DONE} state_t;
  state_t              state, state_n;
  logic                enc, wen, tx_bit, hec_ok;
  logic [HDR_BITS-1:0] hdr_sh, hdr_rx, hdr_sh_n;
  logic [HEC_BITS-1:0] rem, rem_n;
  logic [WHT_BITS-1:0] wht, wht_n;
  logic [RW-1:0]       rep_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SD-1:0]       samp;
  logic [CW-1:0]       ones;
  logic                busy, hdr_ph, stb, adv, last, hdr_last, w, w_n, vote, d, fb, tx_nxt;
  assign busy        = state == HDR || state == HEC;
  assign io.busy     = busy;
  assign io.tx_valid = busy & enc;
  assign io.done_p   = state == DONE;
  assign io.tx_bit   = tx_bit;
  assign io.hdr_rx   = hdr_rx;
  assign io.hec_ok   = hec_ok;
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) state <= IDLE;
    else state <= state_n;
  always_comb begin
    hdr_ph   = state == HDR;
    stb      = io.p_1us & busy & ~io.stop_p & ~io.start_p;
    adv      = stb & (rep_cnt == RW'(FEC_REP - 1));
    last     = bit_cnt == BW'(TOT - 1);
    hdr_last = bit_cnt == BW'(HDR_BITS - 1);
    w        = wen & wht[WHT_BITS-1];
    ones     = CW'(io.rx_bit);
    for (int i = 0; i < FEC_REP - 1; i++) ones = ones + CW'(samp[i]);
    vote     = ones > CW'(FEC_REP / 2);
    d        = enc ? hdr_sh[0] : vote ^ w;
    // transmit HEC phase just shifts the remainder out; receive keeps dividing through the HEC
    fb       = (enc & ~hdr_ph) ? 1'b0 : d ^ rem[HEC_BITS-1];
    rem_n    = {rem[HEC_BITS-2:0], 1'b0} ^ (HEC_POLY & {HEC_BITS{fb}});
    wht_n    = wen ? ({wht[WHT_BITS-2:0], 1'b0} ^ (WHT_POLY & {WHT_BITS{wht[WHT_BITS-1]}})) : wht;
    w_n      = wen & wht_n[WHT_BITS-1];
    hdr_sh_n = hdr_sh >> 1;
    state_n  = io.start_p ? HDR :
               io.stop_p ? IDLE :
               state == DONE ? IDLE :
               !adv ? state :
               hdr_ph ? (hdr_last ? HEC : HDR) :
               (last ? DONE : HEC);
    tx_nxt   = enc & (state_n == HDR ? hdr_sh_n[0] ^ w_n :
                      state_n == HEC ? rem_n[HEC_BITS-1] ^ w_n : 1'b0);
  end
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      enc     <= 1'b0;
      wen     <= 1'b0;
      tx_bit  <= 1'b0;
      hec_ok  <= 1'b0;
      hdr_sh  <= '0;
      hdr_rx  <= '0;
      rem     <= '0;
      wht     <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      samp    <= '0;
    end else if (io.start_p) begin
      enc     <= io.pk_encode;
      wen     <= io.whiten_en;
      tx_bit  <= io.pk_encode & (io.hdr_tx[0] ^ (io.whiten_en & io.wht_init[WHT_BITS-1]));
      hec_ok  <= 1'b0;
      hdr_sh  <= io.hdr_tx;
      hdr_rx  <= '0;
      rem     <= io.hec_init;
      wht     <= io.wht_init;
      rep_cnt <= '0;
      bit_cnt <= '0;
      samp    <= '0;
    end else if (stb) begin
      samp    <= SD'({samp, io.rx_bit});
      rep_cnt <= adv ? '0 : rep_cnt + RW'(1);
      if (adv) begin
        bit_cnt <= bit_cnt + BW'(1);
        hdr_sh  <= hdr_sh_n;
        rem     <= rem_n;
        wht     <= wht_n;
        tx_bit  <= tx_nxt;
        if (!enc && hdr_ph) hdr_rx <= {d, hdr_rx[HDR_BITS-1:1]};
        if (!hdr_ph && last) hec_ok <= enc | (rem_n == '0);
      end
    end
endmodule

// File: tb/tb_pkhdr_codec.sv
// tb_pkhdr_codec: directed transmit, receive, FEC, abort/restart and parameter-variant checks
module tb_pkhdr_codec;
  logic clk_6M = 1'b0;
  logic rstz = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   d;
  logic txs[$];
  logic rxs[$];
  logic lb[$];
  logic [31:0] v;

  pkhdr_codec_if #(.HDR_BITS(10), .HEC_BITS(8), .WHT_BITS(7)) a();
  pkhdr_codec_if #(.HDR_BITS(18), .HEC_BITS(16), .WHT_BITS(7)) b();

  pkhdr_codec u_a (.clk_6M(clk_6M), .rstz(rstz), .io(a));
  pkhdr_codec #(.HDR_BITS(18), .HEC_BITS(16), .HEC_POLY(16'h1021), .FEC_REP(1))
    u_b (.clk_6M(clk_6M), .rstz(rstz), .io(b));

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stb(input bit sel, input logic rb, output logic t, output logic dn);
    if (sel) begin b.rx_bit = rb; t = b.tx_bit; b.p_1us = 1'b1; end
    else begin a.rx_bit = rb; t = a.tx_bit; a.p_1us = 1'b1; end
    @(negedge clk_6M);
    dn = sel ? b.done_p : a.done_p;
    a.p_1us = 1'b0;
    b.p_1us = 1'b0;
    @(negedge clk_6M);
  endtask

  task automatic go(input bit sel, input bit enc, input bit wen, input logic [31:0] hdr,
                    input logic [15:0] hi, input logic [6:0] wi);
    if (sel) begin
      b.pk_encode = enc; b.whiten_en = wen; b.hdr_tx = hdr[17:0];
      b.hec_init = hi; b.wht_init = wi; b.start_p = 1'b1;
    end else begin
      a.pk_encode = enc; a.whiten_en = wen; a.hdr_tx = hdr[9:0];
      a.hec_init = hi[7:0]; a.wht_init = wi; a.start_p = 1'b1;
    end
    @(negedge clk_6M);
    a.start_p = 1'b0;
    b.start_p = 1'b0;
    chk("busy_after_start", 32'(sel ? b.busy : a.busy), 32'd1);
    chk("tx_valid_after_start", 32'(sel ? b.tx_valid : a.tx_valid), 32'(enc));
  endtask

  // strobes n times, records tx_bit per strobe and the strobe count at which done_p first appears
  task automatic run(input bit sel, input int n, input bit use_rx, input int exp_done);
    logic t, dn;
    d = 0;
    txs.delete();
    for (int i = 0; i < n; i++) begin
      stb(sel, use_rx ? rxs[i] : 1'b0, t, dn);
      txs.push_back(t);
      if (dn && d == 0) d = i + 1;
    end
    chk("done_at_strobe", 32'(d), 32'(exp_done));
    chk("done_one_cycle", 32'(sel ? b.done_p : a.done_p), 32'd0);
  endtask

  function automatic int ndiff();
    int c = 0;
    for (int i = 0; i < lb.size(); i++) if (txs[i] !== lb[i]) c++;
    return c;
  endfunction

  initial begin
    a.p_1us = 0; a.start_p = 0; a.stop_p = 0; a.pk_encode = 0; a.whiten_en = 0;
    a.hec_init = '0; a.wht_init = '0; a.hdr_tx = '0; a.rx_bit = 0;
    b.p_1us = 0; b.start_p = 0; b.stop_p = 0; b.pk_encode = 0; b.whiten_en = 0;
    b.hec_init = '0; b.wht_init = '0; b.hdr_tx = '0; b.rx_bit = 0;
    repeat (3) @(negedge clk_6M);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_done", 32'(a.done_p), 32'd0);
    chk("rst_tx_bit", 32'(a.tx_bit), 32'd0);
    chk("rst_tx_valid", 32'(a.tx_valid), 32'd0);
    chk("rst_hec_ok", 32'(a.hec_ok), 32'd0);
    chk("rst_hdr_rx", 32'(a.hdr_rx), 32'd0);
    rstz = 1'b1;
    @(negedge clk_6M);

    go(0, 1, 0, 32'h0, 16'h0, 7'h0);
    run(0, 54, 0, 54);
    v = 0;
    foreach (txs[i]) v = v + 32'(txs[i]);
    chk("zeros_ones_count", v, 32'd0);
    chk("zeros_busy_after", 32'(a.busy), 32'd0);
    chk("tx_hec_ok_forced", 32'(a.hec_ok), 32'd1);

    go(0, 1, 1, 32'h0, 16'h0, 7'h7F);
    run(0, 54, 0, 54);
    v = 0;
    for (int i = 0; i < 15; i++) v[i] = txs[i];
    chk("whiten_first5", v, 32'h01FF);

    go(0, 1, 0, 32'h2B5, 16'h47, 7'h0);
    run(0, 54, 0, 54);
    v = 0;
    d = 0;
    for (int i = 0; i < 18; i++) begin
      v[i] = txs[3*i];
      if (txs[3*i+1] !== txs[3*i] || txs[3*i+2] !== txs[3*i]) d++;
    end
    chk("hdr_hec_info_bits", v, 32'h1AB5);
    chk("repetition_consistent", 32'(d), 32'd0);

    go(0, 1, 1, 32'h2B5, 16'h47, 7'h5A);
    run(0, 54, 0, 54);
    lb = txs;
    rxs = lb;
    go(0, 0, 1, 32'h0, 16'h47, 7'h5A);
    run(0, 54, 1, 54);
    chk("loop_hdr_rx", 32'(a.hdr_rx), 32'h2B5);
    chk("loop_hec_ok", 32'(a.hec_ok), 32'd1);

    rxs = lb;
    for (int i = 0; i < 54; i++) if (i % 3 == (i / 3) % 3) rxs[i] = ~rxs[i];
    go(0, 0, 1, 32'h0, 16'h47, 7'h5A);
    run(0, 54, 1, 54);
    chk("fec1_hdr_rx", 32'(a.hdr_rx), 32'h2B5);
    chk("fec1_hec_ok", 32'(a.hec_ok), 32'd1);

    go(0, 0, 1, 32'h0, 16'h47, 7'h5A);
    run(0, 19, 1, 0);
    a.rx_bit = rxs[19];
    a.stop_p = 1'b1;
    a.p_1us = 1'b1;
    @(negedge clk_6M);
    chk("abort_busy", 32'(a.busy), 32'd0);
    chk("abort_done", 32'(a.done_p), 32'd0);
    a.stop_p = 1'b0;
    a.p_1us = 1'b0;
    @(negedge clk_6M);
    run(0, 40, 0, 0);
    chk("abort_hdr_rx_partial", 32'(a.hdr_rx), 32'h350);
    chk("abort_hec_ok", 32'(a.hec_ok), 32'd0);

    rxs = lb;
    rxs[9] = ~rxs[9];
    rxs[10] = ~rxs[10];
    go(0, 0, 1, 32'h0, 16'h47, 7'h5A);
    run(0, 54, 1, 54);
    chk("fec2_hdr_rx", 32'(a.hdr_rx), 32'h2BD);
    chk("fec2_hec_ok", 32'(a.hec_ok), 32'd0);

    go(0, 1, 1, 32'h2B5, 16'h47, 7'h5A);
    run(0, 29, 0, 0);
    a.start_p = 1'b1;
    a.p_1us = 1'b1;
    @(negedge clk_6M);
    a.start_p = 1'b0;
    a.p_1us = 1'b0;
    chk("restart_busy", 32'(a.busy), 32'd1);
    run(0, 54, 0, 54);
    chk("restart_stream", 32'(ndiff()), 32'd0);
    rxs = txs;
    go(0, 0, 1, 32'h0, 16'h47, 7'h5A);
    run(0, 54, 1, 54);
    chk("restart_hdr_rx", 32'(a.hdr_rx), 32'h2B5);
    chk("restart_hec_ok", 32'(a.hec_ok), 32'd1);

    go(1, 1, 1, 32'h2A5C3, 16'hBEEF, 7'h33);
    run(1, 34, 0, 34);
    rxs = txs;
    go(1, 0, 1, 32'h0, 16'hBEEF, 7'h33);
    run(1, 34, 1, 34);
    chk("var_hdr_rx", 32'(b.hdr_rx), 32'h2A5C3);
    chk("var_hec_ok", 32'(b.hec_ok), 32'd1);
    chk("var_a_idle", 32'(a.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
